// File: rtl/rob_pkg.sv
// -----------------------------------------------------------------------------
// rob_pkg
// Shared definitions for the reorder buffer.
// - ROB_DEPTH  : default number of entries (power of two, 2..32)
// - DATA_W     : default result width
// - ROB_TAG_W  : tag width for the default depth
// - rob_entry_t: one ROB slot {valid, done, regWrite, rd, data}
// -----------------------------------------------------------------------------
package rob_pkg;

  localparam int ROB_DEPTH = 8;
  localparam int DATA_W    = 64;
  localparam int ROB_TAG_W = $clog2(ROB_DEPTH);

  // The data field is sized by the package default. An instance built with a
  // narrower DATA_W uses the low bits and keeps the rest at zero.
  typedef struct packed {
    logic              valid;
    logic              done;
    logic              regWrite;
    logic [4:0]        rd;
    logic [DATA_W-1:0] data;
  } rob_entry_t;

endpackage

// File: rtl/rob_ptr.sv
// -----------------------------------------------------------------------------
// rob_ptr
// Wrapping ROB pointer. DEPTH is a power of two, so the natural binary
// overflow of the counter gives modulo-DEPTH wrap.
// Ports:
//   clk   - clock
//   reset - synchronous active-high reset, clears the pointer
//   inc   - advance by one
//   clr   - synchronous clear (flush); wins over inc
//   ptr   - current pointer value
// -----------------------------------------------------------------------------
module rob_ptr #(
  parameter int  DEPTH = 8,
  localparam int W     = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] ptr
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + W'(1);
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
// In-order retirement buffer. Dispatch allocates entries at the tail, the CDB
// marks them done out of order, and the head retires one entry per cycle once
// it is done.
//
// Build option: define ROB_CDB_BYPASS_EN to let a CDB write that completes
// the head entry retire in the same cycle, forwarding cdb_data straight to
// commit_data. Without it, commit depends only on registered state.
//
// Ports:
//   clk, reset                      - clock, synchronous active-high reset
//   alloc_valid/alloc_ready         - dispatch handshake
//   alloc_rd, alloc_regWrite        - destination fields of the new entry
//   alloc_tag                       - tag granted (the tail pointer)
//   cdb_valid, cdb_tag, cdb_data    - completion broadcast
//   commit_valid/commit_ready       - retirement handshake
//   commit_rd/_data/_regWrite       - head entry fields
//   flush                           - discard all entries
//   count                           - number of occupied entries
// -----------------------------------------------------------------------------
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int DEPTH  = ROB_DEPTH,
  parameter int DATA_W = rob_pkg::DATA_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alloc_valid,
  output logic                       alloc_ready,
  input  logic [4:0]                 alloc_rd,
  input  logic                       alloc_regWrite,
  output logic [$clog2(DEPTH)-1:0]   alloc_tag,
  input  logic                       cdb_valid,
  input  logic [$clog2(DEPTH)-1:0]   cdb_tag,
  input  logic [DATA_W-1:0]          cdb_data,
  output logic                       commit_valid,
  input  logic                       commit_ready,
  output logic [4:0]                 commit_rd,
  output logic [DATA_W-1:0]          commit_data,
  output logic                       commit_regWrite,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int TAG_W = $clog2(DEPTH);
  localparam int CNT_W = TAG_W + 1;

  rob_entry_t        entries [DEPTH];
  rob_entry_t        head_e;
  logic [TAG_W-1:0]  head;
  logic [TAG_W-1:0]  tail;
  logic [CNT_W-1:0]  count_q;
  logic              do_alloc;
  logic              do_commit;
  logic              cdb_hit;

  rob_ptr #(.DEPTH(DEPTH)) u_head_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (do_commit),
    .clr   (flush),
    .ptr   (head)
  );

  rob_ptr #(.DEPTH(DEPTH)) u_tail_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (do_alloc),
    .clr   (flush),
    .ptr   (tail)
  );

  assign head_e = entries[head];

  // Full test uses registered count only, so a commit in the same cycle never
  // opens a slot for dispatch.
  assign alloc_ready = (count_q != CNT_W'(DEPTH));
  assign do_alloc    = alloc_valid & alloc_ready & ~flush;
  assign alloc_tag   = tail;
  assign count       = count_q;

  // Late or duplicate broadcasts (entry empty or already done) are dropped.
  assign cdb_hit = cdb_valid & entries[cdb_tag].valid & ~entries[cdb_tag].done;

`ifdef ROB_CDB_BYPASS_EN
  logic bypass;
  assign bypass       = cdb_valid & (cdb_tag == head) & head_e.valid & ~head_e.done;
  assign commit_valid = head_e.valid & (head_e.done | bypass) & ~flush;
  assign commit_data  = bypass ? cdb_data : head_e.data[DATA_W-1:0];
`else
  assign commit_valid = head_e.valid & head_e.done & ~flush;
  assign commit_data  = head_e.data[DATA_W-1:0];
`endif

  assign commit_rd       = head_e.rd;
  assign commit_regWrite = head_e.regWrite;
  assign do_commit       = commit_valid & commit_ready;

  // Write order matters: CDB, then allocate, then commit clear, so that a
  // bypassed head completion is still cleared. Allocate and commit never hit
  // the same slot: the buffer is empty (no commit) or full (no allocate).
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      // NOTE: the entry array is reset (not just the pointers) because the
      // valid bits must drop and commit fields must read zero out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
      count_q <= '0;
    end else begin
      if (cdb_hit) begin
        entries[cdb_tag].done               <= 1'b1;
        entries[cdb_tag].data[DATA_W-1:0]   <= cdb_data;
      end
      if (do_alloc) begin
        entries[tail] <= '{valid:    1'b1,
                           done:     1'b0,
                           regWrite: alloc_regWrite,
                           rd:       alloc_rd,
                           data:     '0};
      end
      if (do_commit) begin
        entries[head] <= '0;
      end
      case ({do_alloc, do_commit})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// -----------------------------------------------------------------------------
// tb_reorder_buffer
// Self-checking bench for reorder_buffer (DEPTH=8, DATA_W=64). A table of
// per-cycle vectors covers allocate/complete/retire ordering; hand-written
// sequences cover full/wrap, full with simultaneous commit, flush, mid-run
// reset and CDB-to-commit latency. A scoreboard queue holds the expected
// retirement stream, filled at allocation time and drained by a monitor.
// Expectations follow ROB_CDB_BYPASS_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_reorder_buffer;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 64;
  localparam int TAG_W  = 3;

  logic              clk;
  logic              reset;
  logic              alloc_valid;
  logic              alloc_ready;
  logic [4:0]        alloc_rd;
  logic              alloc_regWrite;
  logic [TAG_W-1:0]  alloc_tag;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              commit_valid;
  logic              commit_ready;
  logic [4:0]        commit_rd;
  logic [DATA_W-1:0] commit_data;
  logic              commit_regWrite;
  logic              flush;
  logic [TAG_W:0]    count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  rd;
    logic        rw;
    logic [63:0] data;
  } commit_t;

  typedef struct {
    logic        av;
    logic [4:0]  rd;
    logic [63:0] res;   // value this entry will later receive on the CDB
    logic        cv;
    logic [2:0]  tag;
    logic [63:0] cd;
    logic        cr;
    logic        er;
    logic [2:0]  et;
    logic [3:0]  ec;
    logic        ecv;
  } vec_t;

  commit_t exp_q[$];
  commit_t mon_e;
  vec_t    vecs[$];

  reorder_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .alloc_valid     (alloc_valid),
    .alloc_ready     (alloc_ready),
    .alloc_rd        (alloc_rd),
    .alloc_regWrite  (alloc_regWrite),
    .alloc_tag       (alloc_tag),
    .cdb_valid       (cdb_valid),
    .cdb_tag         (cdb_tag),
    .cdb_data        (cdb_data),
    .commit_valid    (commit_valid),
    .commit_ready    (commit_ready),
    .commit_rd       (commit_rd),
    .commit_data     (commit_data),
    .commit_regWrite (commit_regWrite),
    .flush           (flush),
    .count           (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] rd, input logic rw,
                       input logic cv, input logic [2:0] tag, input logic [63:0] cd,
                       input logic cr, input logic fl);
    alloc_valid    = av;
    alloc_rd       = rd;
    alloc_regWrite = rw;
    cdb_valid      = cv;
    cdb_tag        = tag;
    cdb_data       = cd;
    commit_ready   = cr;
    flush          = fl;
  endtask

  task automatic idle(input logic cr);
    drive(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 64'h0, cr, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [4:0] rd, input logic rw, input logic [63:0] data);
    commit_t e;
    e.rd = rd; e.rw = rw; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(1'b0);
    repeat (2) step();
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic add_vec(input logic av, input logic [4:0] rd, input logic [63:0] res,
                         input logic cv, input logic [2:0] tag, input logic [63:0] cd,
                         input logic cr, input logic er, input logic [2:0] et,
                         input logic [3:0] ec, input logic ecv);
    vec_t v;
    v.av = av; v.rd = rd; v.res = res; v.cv = cv; v.tag = tag; v.cd = cd; v.cr = cr;
    v.er = er; v.et = et; v.ec = ec; v.ecv = ecv;
    vecs.push_back(v);
  endtask

  // Retirement monitor: every accepted commit must match the oldest entry.
  always @(negedge clk) begin
    if (!reset && commit_valid && commit_ready) begin
      if (exp_q.size() == 0) begin
        check("commit_unexpected", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("commit_rd", 64'(commit_rd), 64'(mon_e.rd));
        check("commit_data", commit_data, mon_e.data);
        check("commit_regWrite", 64'(commit_regWrite), 64'(mon_e.rw));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    idle(1'b0);
    do_reset();

    // ---------------- reset state ----------------
    @(negedge clk);
    check("rst_alloc_ready", 64'(alloc_ready), 64'd1);
    check("rst_alloc_tag", 64'(alloc_tag), 64'd0);
    check("rst_commit_valid", 64'(commit_valid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_commit_rd", 64'(commit_rd), 64'd0);
    check("rst_commit_data", commit_data, 64'd0);
    check("rst_commit_regWrite", 64'(commit_regWrite), 64'd0);
    step();

    // ---------------- table: allocate 3, complete out of order ----------------
    //      av rd    res     cv tag cd      cr er et ec ecv
    add_vec(0, 5'd0, 64'h0,  0, 0, 64'h0,  0, 1, 0, 0, 0);
    add_vec(1, 5'd1, 64'h11, 0, 0, 64'h0,  0, 1, 0, 0, 0);
    add_vec(1, 5'd2, 64'h22, 0, 0, 64'h0,  0, 1, 1, 1, 0);
    add_vec(1, 5'd3, 64'h33, 0, 0, 64'h0,  0, 1, 2, 2, 0);
    add_vec(0, 5'd0, 64'h0,  0, 0, 64'h0,  1, 1, 3, 3, 0);
    add_vec(0, 5'd0, 64'h0,  1, 2, 64'h33, 1, 1, 3, 3, 0);
`ifdef ROB_CDB_BYPASS_EN
    add_vec(0, 5'd0, 64'h0,  1, 0, 64'h11, 1, 1, 3, 3, 1);
    add_vec(0, 5'd0, 64'h0,  1, 1, 64'h22, 1, 1, 3, 2, 1);
    add_vec(0, 5'd0, 64'h0,  0, 0, 64'h0,  1, 1, 3, 1, 1);
    add_vec(0, 5'd0, 64'h0,  0, 0, 64'h0,  1, 1, 3, 0, 0);
`else
    add_vec(0, 5'd0, 64'h0,  1, 0, 64'h11, 1, 1, 3, 3, 0);
    add_vec(0, 5'd0, 64'h0,  1, 1, 64'h22, 1, 1, 3, 3, 1);
    add_vec(0, 5'd0, 64'h0,  0, 0, 64'h0,  1, 1, 3, 2, 1);
    add_vec(0, 5'd0, 64'h0,  0, 0, 64'h0,  1, 1, 3, 1, 1);
`endif
    add_vec(0, 5'd0, 64'h0,  0, 0, 64'h0,  1, 1, 3, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].av, vecs[i].rd, 1'b1, vecs[i].cv, vecs[i].tag, vecs[i].cd, vecs[i].cr, 1'b0);
      if (vecs[i].av && vecs[i].er) push_exp(vecs[i].rd, 1'b1, vecs[i].res);
      @(negedge clk);
      check($sformatf("v%0d_alloc_ready", i), 64'(alloc_ready), 64'(vecs[i].er));
      check($sformatf("v%0d_alloc_tag", i), 64'(alloc_tag), 64'(vecs[i].et));
      check($sformatf("v%0d_count", i), 64'(count), 64'(vecs[i].ec));
      check($sformatf("v%0d_commit_valid", i), 64'(commit_valid), 64'(vecs[i].ecv));
      step();
    end

    // ---------------- full, refused 9th, full+commit, wrap ----------------
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 5'(i + 4), (i % 2 == 1), 1'b0, 3'd0, 64'h0, 1'b0, 1'b0);
      push_exp(5'(i + 4), (i % 2 == 1), 64'hA0 + 64'(i));
      @(negedge clk);
      check("fill_alloc_tag", 64'(alloc_tag), 64'(i));
      step();
    end
    drive(1'b1, 5'd31, 1'b1, 1'b0, 3'd0, 64'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("full_alloc_ready", 64'(alloc_ready), 64'd0);
    check("full_count", 64'(count), 64'd8);
    step();
    idle(1'b0);
    @(negedge clk);
    check("ninth_ignored_count", 64'(count), 64'd8);
    check("ninth_ignored_tag", 64'(alloc_tag), 64'd0);
    step();
    drive(1'b0, 5'd0, 1'b0, 1'b1, 3'd0, 64'hA0, 1'b0, 1'b0);
    step();
    // full + head done + alloc and commit together
    drive(1'b1, 5'd30, 1'b1, 1'b0, 3'd0, 64'h0, 1'b1, 1'b0);
    @(negedge clk);
    check("fullcommit_valid", 64'(commit_valid), 64'd1);
    check("fullcommit_ready", 64'(alloc_ready), 64'd0);
    step();
    idle(1'b0);
    @(negedge clk);
    check("fullcommit_count", 64'(count), 64'd7);
    check("after_commit_ready", 64'(alloc_ready), 64'd1);
    step();
    drive(1'b1, 5'd12, 1'b1, 1'b0, 3'd0, 64'h0, 1'b0, 1'b0);
    push_exp(5'd12, 1'b1, 64'hB0);
    @(negedge clk);
    check("wrap_alloc_tag", 64'(alloc_tag), 64'd0);
    step();
    for (int k = 1; k <= DEPTH; k++) begin
      logic [2:0] t;
      t = 3'(k % DEPTH);
      drive(1'b0, 5'd0, 1'b0, 1'b1, t, (t == 3'd0) ? 64'hB0 : 64'hA0 + 64'(t), 1'b1, 1'b0);
      step();
    end
    idle(1'b1);
    repeat (3) step();
    @(negedge clk);
    check("drain_count", 64'(count), 64'd0);
    step();

    // ---------------- flush with cdb and alloc ----------------
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 5'(i + 1), 1'b1, 1'b0, 3'd0, 64'h0, 1'b0, 1'b0);
      push_exp(5'(i + 1), 1'b1, 64'hC0 + 64'(i));
      step();
    end
    drive(1'b0, 5'd0, 1'b0, 1'b1, 3'd1, 64'hC1, 1'b0, 1'b0);
    step();
    drive(1'b0, 5'd0, 1'b0, 1'b1, 3'd0, 64'hC0, 1'b0, 1'b0);
    step();
    idle(1'b0);
    @(negedge clk);
    check("preflush_commit_valid", 64'(commit_valid), 64'd1);
    check("preflush_count", 64'(count), 64'd5);
    step();
    drive(1'b1, 5'd9, 1'b1, 1'b1, 3'd4, 64'hEE, 1'b1, 1'b1);
    @(negedge clk);
    check("flush_commit_valid", 64'(commit_valid), 64'd0);
    step();
    exp_q.delete();
    idle(1'b1);
    @(negedge clk);
    check("postflush_count", 64'(count), 64'd0);
    check("postflush_tag", 64'(alloc_tag), 64'd0);
    step();
    drive(1'b0, 5'd0, 1'b0, 1'b1, 3'd2, 64'hDEAD, 1'b1, 1'b0);
    step();
    idle(1'b1);
    @(negedge clk);
    check("stale_cdb_commit_valid", 64'(commit_valid), 64'd0);
    check("stale_cdb_count", 64'(count), 64'd0);
    step();
    drive(1'b1, 5'd7, 1'b1, 1'b0, 3'd0, 64'h0, 1'b1, 1'b0);
    push_exp(5'd7, 1'b1, 64'h77);
    step();
    drive(1'b0, 5'd0, 1'b0, 1'b1, 3'd0, 64'h77, 1'b1, 1'b0);
    step();
    idle(1'b1);
    repeat (2) step();

    // ---------------- reset mid-operation beats flush/alloc ----------------
    drive(1'b1, 5'd3, 1'b1, 1'b0, 3'd0, 64'h0, 1'b0, 1'b0);
    step();
    step();
    reset = 1'b1;
    drive(1'b1, 5'd5, 1'b1, 1'b1, 3'd1, 64'h99, 1'b1, 1'b1);
    step();
    reset = 1'b0;
    exp_q.delete();
    idle(1'b0);
    @(negedge clk);
    check("midreset_count", 64'(count), 64'd0);
    check("midreset_tag", 64'(alloc_tag), 64'd0);
    check("midreset_commit_data", commit_data, 64'd0);
    step();

    // ---------------- CDB-to-commit latency, duplicate CDB ----------------
    drive(1'b1, 5'd10, 1'b1, 1'b0, 3'd0, 64'h0, 1'b0, 1'b0);
    push_exp(5'd10, 1'b1, 64'hAB);
    step();
    drive(1'b0, 5'd0, 1'b0, 1'b1, 3'd0, 64'hAB, 1'b1, 1'b0);
    @(negedge clk);
`ifdef ROB_CDB_BYPASS_EN
    check("lat_same_cycle_valid", 64'(commit_valid), 64'd1);
    check("lat_same_cycle_data", commit_data, 64'hAB);
`else
    check("lat_same_cycle_valid", 64'(commit_valid), 64'd0);
`endif
    step();
    idle(1'b1);
    @(negedge clk);
`ifdef ROB_CDB_BYPASS_EN
    check("lat_next_cycle_valid", 64'(commit_valid), 64'd0);
`else
    check("lat_next_cycle_valid", 64'(commit_valid), 64'd1);
    check("lat_next_cycle_data", commit_data, 64'hAB);
`endif
    step();
    drive(1'b1, 5'd11, 1'b0, 1'b0, 3'd0, 64'h0, 1'b0, 1'b0);
    push_exp(5'd11, 1'b0, 64'h55);
    step();
    drive(1'b0, 5'd0, 1'b0, 1'b1, 3'd1, 64'h55, 1'b0, 1'b0);
    step();
    drive(1'b0, 5'd0, 1'b0, 1'b1, 3'd1, 64'h66, 1'b0, 1'b0);
    step();
    idle(1'b1);
    @(negedge clk);
    check("dup_cdb_data", commit_data, 64'h55);
    step();
    idle(1'b0);
    step();

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameter DEPTH, default 8, sets the number of ROB entries; it SHALL be a power of two, 2..32.
REQ-002 Parameter DATA_W, default 64, sets the result data width.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1: synchronous active-high reset.
REQ-005 Port alloc_valid, input, 1: dispatch requests an entry.
REQ-006 Port alloc_ready, output, 1: an entry is available.
REQ-007 Port alloc_rd, input, 5: destination register of the dispatched instruction.
REQ-008 Port alloc_regWrite, input, 1: the instruction writes alloc_rd.
REQ-009 Port alloc_tag, output, log2(DEPTH): tag granted, equal to the tail pointer.
REQ-010 Port cdb_valid, input, 1: completion broadcast.
REQ-011 Port cdb_tag, input, log2(DEPTH): entry completing.
REQ-012 Port cdb_data, input, DATA_W: result value.
REQ-013 Port commit_valid, output, 1: the head entry is retiring.
REQ-014 Port commit_ready, input, 1: the register file accepts the commit.
REQ-015 Port commit_rd, output, 5; port commit_data, output, DATA_W; port commit_regWrite, output, 1: fields of the head entry.
REQ-016 Port flush, input, 1: mispredict; discard all entries.
REQ-017 Port count, output, log2(DEPTH)+1: number of occupied entries.

Function
REQ-018 Each entry SHALL hold valid, done, regWrite, rd and data; head and tail pointers SHALL wrap modulo DEPTH.
REQ-019 alloc_ready SHALL be (count != DEPTH); it SHALL NOT depend on a same-cycle commit.
REQ-020 An allocation (alloc_valid & alloc_ready) SHALL write {valid=1, done=0, rd, regWrite} at the tail and advance the tail by 1; alloc_tag is valid in the same cycle.
REQ-021 A CDB write to a valid, not-done entry SHALL set done=1 and store cdb_data; a CDB write to an invalid or already-done entry SHALL be ignored.
REQ-022 commit_valid SHALL be combinational: head valid & head done & ~flush; it SHALL be 0 when the buffer is empty.
REQ-023 On commit_valid & commit_ready, the head entry SHALL be cleared and the head SHALL advance by 1; this gives in-order retirement, one per cycle.
REQ-024 count SHALL increment on allocate, decrement on commit, and stay unchanged when both occur in the same cycle.
REQ-025 flush SHALL have priority over allocate, CDB and commit: next cycle all valid=0, head=tail=0, count=0.
REQ-026 Minimum latency from a CDB write to commit SHALL be 1 cycle (the entry is marked done at the edge, then commits) unless REQ-031 applies.

Reset
REQ-027 When reset is high at a clock edge, the block SHALL take all entries invalid, head=tail=0 and count=0.
REQ-028 After reset the outputs SHALL be alloc_ready=1, alloc_tag=0, commit_valid=0, count=0; commit_rd, commit_data and commit_regWrite SHALL be 0.
REQ-029 Reset asserted mid-operation SHALL behave as REQ-027, overriding flush and all other inputs.

Configuration
REQ-030 Macro ROB_CDB_BYPASS_EN SHALL select the completion-bypass feature.
REQ-031 With ROB_CDB_BYPASS_EN defined, a CDB write whose tag equals the head of a valid, not-done head entry SHALL make commit_valid=1 in the same cycle, with commit_data=cdb_data (0-cycle latency).
REQ-032 Without ROB_CDB_BYPASS_EN, REQ-026 latency SHALL hold and commit SHALL NOT depend combinationally on the cdb_* inputs.

Structure
REQ-033 Package rob_pkg SHALL hold the ROB_DEPTH and DATA_W defaults, ROB_TAG_W=$clog2(ROB_DEPTH), and the struct rob_entry_t {valid, done, regWrite, rd[4:0], data}.
REQ-034 Sub-module rob_ptr (wrapping pointer with increment and clear, parameter DEPTH) SHALL be instantiated twice, once for head and once for tail.

Verification
REQ-035 Reset, then allocate 3 entries (rd=1,2,3) -> alloc_tag=0,1,2, count=3, commit_valid=0.
REQ-036 CDB writes tag 2 (data 0x33), then tag 0 (0x11), then tag 1 (0x22) -> commits occur in order rd1=0x11, rd2=0x22, rd3=0x33, each 1 cycle after the enabling CDB write, one per cycle.
REQ-037 Allocate 8 entries with no commits -> alloc_ready=0 and a 9th alloc_valid is ignored; commit entry 0 -> alloc_ready=1 the next cycle; the next allocation gets tag 0 (wrap).
REQ-038 Buffer full and head done, with alloc_valid and commit_ready both high -> commit occurs, allocation is refused, and count goes from 8 to 7.
REQ-039 5 entries, 2 of them done, flush=1 together with cdb_valid and alloc_valid -> commit_valid=0 that cycle; next cycle count=0, alloc_tag=0; a CDB write to an old tag is ignored.
REQ-040 Run with ROB_CDB_BYPASS_EN defined: head entry not done, CDB write to the head tag with 0xAB -> commit_valid=1 and commit_data=0xAB in the same cycle; without the macro, the commit occurs the following cycle.
